// File: rtl/stoch_decode_mat.sv
// stoch_decode_mat: counts the ones in every element's bitstream over a 2^WINDOW_LOG2 sample window.
// Optional macro STOCH_DECODE_MAT_BIPOLAR_EN selects bipolar (2*count - N) output; default is unipolar count.
module stoch_decode_mat #(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLS    = 2,
  parameter int WINDOW_LOG2 = 8,
  localparam int OUT_WIDTH  = WINDOW_LOG2 + 2
) (
  input  logic                                             CLK,
  input  logic                                             RST,
  input  logic                                             start,
  input  logic                                             in_valid,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                A,
  input  logic                                             y_ready,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUT_WIDTH-1:0] Y,
  output logic                                             y_valid,
  output logic                                             busy
);

  localparam int CW = WINDOW_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                                       state_r;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0]    cnt_r;
  logic [WINDOW_LOG2-1:0]                       scnt_r;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][CW-1:0]    cnt_nxt_s;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][OUT_WIDTH-1:0] y_nxt_s;
  logic                                         last_s;

  // Counter width is WINDOW_LOG2+1, so the full-window count N never wraps.
  function automatic logic [OUT_WIDTH-1:0] to_out(input logic [CW-1:0] cnt);
`ifdef STOCH_DECODE_MAT_BIPOLAR_EN
    to_out = {cnt, 1'b0} - (OUT_WIDTH'(1) << WINDOW_LOG2);
`else
    to_out = {1'b0, cnt};
`endif
  endfunction

  assign last_s = &scnt_r;

  // Next element counts including this cycle's sample, and their output encoding.
  always_comb begin
    cnt_nxt_s = cnt_r;
    y_nxt_s   = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      for (int j = 0; j < NUM_COLS; j++) begin
        cnt_nxt_s[i][j] = cnt_r[i][j] + CW'(A[i][j]);
        y_nxt_s[i][j]   = to_out(cnt_nxt_s[i][j]);
      end
    end
  end

  // Window FSM with registered Y, y_valid and busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      scnt_r  <= '0;
      Y       <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= ACCUM;
            busy    <= 1'b1;
            cnt_r   <= '0;
            scnt_r  <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            cnt_r  <= cnt_nxt_s;
            scnt_r <= scnt_r + WINDOW_LOG2'(1);
            // The N-th sample is folded straight into Y: no extra pipeline cycle.
            if (last_s) begin
              Y       <= y_nxt_s;
              y_valid <= 1'b1;
              busy    <= 1'b0;
              state_r <= HOLD;
            end
          end
        end
        HOLD: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (start) begin
              state_r <= ACCUM;
              busy    <= 1'b1;
              cnt_r   <= '0;
              scnt_r  <= '0;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          y_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stoch_decode_mat.md
STOCH_DECODE_MAT -- requirements
Module: stoch_decode_mat

Interface
REQ-001 The module SHALL have parameter NUM_ROWS, default 2, matrix row count.
REQ-002 The module SHALL have parameter NUM_COLS, default 2, matrix column count.
REQ-003 The module SHALL have parameter WINDOW_LOG2, default 8, where N = 2^WINDOW_LOG2 is the number of valid samples per decode window.
REQ-004 The module SHALL define localparam OUT_WIDTH = WINDOW_LOG2+2, the per-element result width.
REQ-005 The module SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port start, input, 1 bit: request to begin a decode window.
REQ-008 The module SHALL have port in_valid, input, 1 bit: the A bits this cycle are a sample.
REQ-009 The module SHALL have port A, input, [NUM_ROWS-1:0][NUM_COLS-1:0]: stochastic bitstream matrix, one bit per element.
REQ-010 The module SHALL have port y_ready, input, 1 bit: the consumer accepts Y.
REQ-011 The module SHALL have port Y, output, [NUM_ROWS-1:0][NUM_COLS-1:0][OUT_WIDTH-1:0]: the decoded matrix.
REQ-012 The module SHALL have port y_valid, output, 1 bit: Y holds a completed result.
REQ-013 The module SHALL have port busy, output, 1 bit: high while in ACCUM.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-015 In IDLE with start=1, on the next edge the FSM SHALL enter ACCUM and clear all element counters and the sample counter.
REQ-016 In ACCUM, each edge with in_valid=1 SHALL add A[i][j] to counter[i][j] for every element and increment the sample counter; edges with in_valid=0 SHALL change nothing.
REQ-017 Element counters SHALL be WINDOW_LOG2+1 bits wide and SHALL never wrap, since the maximum count is N.
REQ-018 On the edge that accepts the N-th valid sample (that sample included), Y SHALL be loaded with the final counts, y_valid SHALL be set, and the FSM SHALL enter HOLD.
REQ-019 Latency SHALL be exactly N valid-sample edges from ACCUM entry to y_valid=1, with no extra pipeline cycle.
REQ-020 In HOLD, Y and y_valid SHALL stay stable until y_ready=1.
REQ-021 In HOLD with y_ready=1 and start=0, the FSM SHALL clear y_valid and enter IDLE.
REQ-022 In HOLD with y_ready=1 and start=1 on the same edge, the FSM SHALL clear y_valid, clear the counters and enter ACCUM directly.
REQ-023 In HOLD with y_ready=0, start SHALL be ignored.
REQ-024 start SHALL be ignored in ACCUM; a running window is never restarted.
REQ-025 y_ready SHALL be ignored outside HOLD.
REQ-026 Y SHALL retain its last result in IDLE and ACCUM and SHALL change only on the window-completion edge or on reset.
REQ-027 busy SHALL equal (state==ACCUM) and SHALL be registered.

Reset
REQ-028 RST=1 SHALL immediately force IDLE, all counters to 0, Y to all-zero, y_valid=0 and busy=0, regardless of clock.
REQ-029 Reset asserted mid-ACCUM or mid-HOLD SHALL discard the partial or pending result; no y_valid follows.
REQ-030 After RST deasserts, the first start SHALL be honoured on the first clock edge.

Configuration
REQ-031 The configuration SHALL be selected by macro STOCH_DECODE_MAT_BIPOLAR_EN.
REQ-032 With STOCH_DECODE_MAT_BIPOLAR_EN defined, Y[i][j] SHALL be the two's-complement value 2*count - N (range -N..+N).
REQ-033 Without STOCH_DECODE_MAT_BIPOLAR_EN, Y[i][j] SHALL be count zero-extended (unipolar, range 0..N).
REQ-034 Timing, handshake and reset behaviour SHALL be identical in both configurations.

Verification (2x2, WINDOW_LOG2=4, N=16)
REQ-035 Unipolar: start, then 16 valid cycles with A[0][0]=1 always, A[0][1]=0 always, A[1][0] alternating 1/0, A[1][1]=1 on 4 cycles -> y_valid on the 16th sample edge with Y = {16, 0, 8, 4}.
REQ-036 Same stimulus with 7 gap cycles (in_valid=0) interleaved -> identical Y, with y_valid delayed by exactly 7 cycles.
REQ-037 Bipolar build, same stimulus as REQ-035 -> Y = {+16, -16, 0, -8} in 6-bit two's complement.
REQ-038 HOLD held 5 cycles with y_ready=0 and start pulsed -> Y and y_valid stable; then y_ready=1 with start=1 -> y_valid=0 and busy=1 on the next cycle with counters cleared.
REQ-039 RST pulsed after 9 of 16 samples -> Y=0, y_valid=0, busy=0 at once; a new start then yields a correct full 16-sample result.
REQ-040 start pulsed during ACCUM -> window still completes after the original 16 samples with unaffected counts.
